masked_table_rom_ldr: RTL
=========================

# masked_table_rom_ldr

Parametrised dual-port synchronous lookup table for masked S-box shares, with a runtime reload engine. It holds one 2^ADDR_W × DATA_W table in inferred block RAM and serves two independent lookup ports with a tracked valid pipeline. A streaming loader rewrites the whole table in place, so fresh-mask tables can be installed without reconfiguring the FPGA. It sits in the masked S-box datapath in place of fixed-content BRAM instances.

## Interface
- ADDR_W, default 10: table address width; depth = 2^ADDR_W.
- DATA_W, default 8: table word width.
- OUT_REG, default 1: 1 adds an output register stage (read latency 2); 0 gives read latency 1.

- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- en  in  1  lookup pipeline enable; 0 freezes both read pipelines.
- req_a  in  1  port A lookup request.
- addr_a  in  ADDR_W  port A address.
- req_b  in  1  port B lookup request.
- addr_b  in  ADDR_W  port B address.
- dout_a, dout_b  out  DATA_W  lookup results.
- vld_a, vld_b  out  1  result valid, aligned with dout_a / dout_b.
- load_start  in  1  single-cycle pulse that begins a full-table reload.
- load_valid  in  1  load_data is valid.
- load_data  in  DATA_W  next table word, in ascending address order.
- load_ready  out  1  loader accepts a word this cycle.
- busy  out  1  loader is active; lookups are refused.
- load_done  out  1  one-cycle pulse when a reload completes.
- table_ok  out  1  table holds a completely loaded image.
- drop_err  out  1  sticky flag: a lookup was refused while busy.

## Operation
- FSM states: IDLE, LOAD, DONE.
- IDLE → LOAD on load_start. In the same transition, wptr := 0 and table_ok := 0.
- load_start is ignored in LOAD and DONE.
- LOAD:
  - load_ready = 1.
  - On each load_valid & load_ready: mem[wptr] := load_data, then wptr += 1.
  - Gaps in load_valid only stall the loader; no word is lost or duplicated.
  - The write at wptr = 2^ADDR_W−1 moves the FSM to DONE; wptr wraps to 0.
- DONE (one cycle): load_done = 1 and table_ok := 1, then return to IDLE.
- busy = 1 in LOAD and DONE; load_ready = 1 only in LOAD.
- Lookups are served only when the state is IDLE and en = 1. A request in that cycle enters its port pipeline with valid = 1.
- A req_a or req_b arriving while busy is discarded: it produces no vld and sets drop_err. drop_err clears only on rst.
- Lookups in IDLE are served even when table_ok = 0; the consumer is responsible for checking table_ok.
- Both ports may read the same address in the same cycle; both get the same data.
- No read/write collision can occur, because reads and writes are mutually exclusive by state.
- Memory contents are not reset. After rst, contents are whatever was last written (or the power-up zeros).

## Timing
- Reset values: dout_a = dout_b = 0; vld_a = vld_b = 0; load_ready = 0; busy = 0; load_done = 0; table_ok = 0; drop_err = 0; state = IDLE; wptr = 0.
- Read latency is counted from a request edge to vld/dout:
  - OUT_REG = 1: 2 cycles.
  - OUT_REG = 0: 1 cycle.
- Full throughput: one lookup per port per cycle.
- en = 0: all read pipeline stages, dout and vld hold their values. Loader operation is unaffected by en.
- load_start in IDLE together with req_a/req_b in the same cycle: the lookup is served (the state is still IDLE) and busy rises the next cycle.
- Lookups already in flight when busy rises complete normally. Reads issued in the last IDLE cycle return pre-load data.
- Minimum reload duration is 2^ADDR_W + 1 cycles after load_start: one word per cycle, plus the DONE cycle.
- rst mid-load: the FSM returns to IDLE with wptr = 0 and table_ok = 0. The partially written table is retained. The next load_start restarts at address 0.

## Test plan
- Reset: assert rst asynchronously mid-cycle → all outputs read 0 immediately.
- Full load (ADDR_W = 10, DATA_W = 8, OUT_REG = 1): pulse load_start, stream data = addr[7:0] ^ 8'h5A with load_valid held high.
  - load_done pulses exactly 1025 cycles after load_start; table_ok = 1.
  - Read addr_a = 0x000 and addr_b = 0x3FF → 0x5A and 0xA5 with vld after 2 cycles.
- Throttled load: random load_valid gaps (about 50 % duty) → same table contents; every address read back-to-back on both ports matches, with vld continuous at one result per cycle.
- Refusal: issue req_a during LOAD → no vld_a, drop_err = 1 and stays 1 through later reads. Also issue req_b in the cycle of load_start → vld_b after 2 cycles with old data.
- Reset mid-load: rst at wptr = 100 → busy = 0, table_ok = 0. A new load writing 8'hFF everywhere, then reading address 0 → 0xFF.
- Stall and latency mode: hold en = 0 for 3 cycles with a read in flight → vld/dout frozen, then delivered after en returns. Repeat with OUT_REG = 0 → latency is 1 cycle.

Source files
------------

// File: rtl/masked_table_rom_ldr.sv
// Dual-port synchronous lookup table for masked S-box shares.
// One 2^ADDR_W x DATA_W table serves two independent read ports, each with
// a valid pipeline. A streaming loader rewrites the whole table in place.
// Reads and writes never overlap, because they are only allowed in
// different FSM states.
module masked_table_rom_ldr #(
    parameter int ADDR_W  = 10,
    parameter int DATA_W  = 8,
    parameter int OUT_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              req_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic              req_b,
    input  logic [ADDR_W-1:0] addr_b,
    output logic [DATA_W-1:0] dout_a,
    output logic [DATA_W-1:0] dout_b,
    output logic              vld_a,
    output logic              vld_b,
    input  logic              load_start,
    input  logic              load_valid,
    input  logic [DATA_W-1:0] load_data,
    output logic              load_ready,
    output logic              busy,
    output logic              load_done,
    output logic              table_ok,
    output logic              drop_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   wptr_q, wptr_d;
    logic                table_ok_q, table_ok_d;
    logic                drop_err_q, drop_err_d;
    logic                busy_q, load_ready_q, load_done_q;
    logic                serve_s, we_s;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Read stage 1 (memory output register) and its valid bits
    logic [DATA_W-1:0]   rd_a_q, rd_b_q;
    logic                v1_a_q, v1_b_q;

    // Lookups are accepted only while the loader is idle and the pipe runs
    assign serve_s = (state_q == ST_IDLE) && en;
    assign we_s    = (state_q == ST_LOAD) && load_valid;

    // Next-state logic for the reload FSM, write pointer and status flags
    always_comb begin
        state_d    = state_q;
        wptr_d     = wptr_q;
        table_ok_d = table_ok_q;
        case (state_q)
            ST_IDLE: begin
                if (load_start) begin
                    state_d    = ST_LOAD;
                    wptr_d     = {ADDR_W{1'b0}};
                    table_ok_d = 1'b0;
                end else begin
                    state_d    = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (load_valid) begin
                    wptr_d = wptr_q + ADDR_W'(1);
                    if (wptr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d    = ST_IDLE;
                table_ok_d = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // A request while the loader owns the table is dropped and remembered
        drop_err_d = drop_err_q | ((req_a | req_b) & (state_q != ST_IDLE));
    end

    // FSM state, pointer and registered status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wptr_q       <= {ADDR_W{1'b0}};
            table_ok_q   <= 1'b0;
            drop_err_q   <= 1'b0;
            busy_q       <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            wptr_q       <= wptr_d;
            table_ok_q   <= table_ok_d;
            drop_err_q   <= drop_err_d;
            busy_q       <= (state_d != ST_IDLE);
            load_ready_q <= (state_d == ST_LOAD);
            load_done_q  <= (state_d == ST_DONE);
        end
    end

    // Table write port; contents are deliberately not reset
    always_ff @(posedge clk) begin
        if (we_s) begin
            mem[wptr_q] <= load_data;
        end
    end

    // Read stage 1: memory read and valid tracking, frozen while en is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_a_q <= {DATA_W{1'b0}};
            rd_b_q <= {DATA_W{1'b0}};
            v1_a_q <= 1'b0;
            v1_b_q <= 1'b0;
        end else if (en) begin
            rd_a_q <= mem[addr_a];
            rd_b_q <= mem[addr_b];
            v1_a_q <= serve_s & req_a;
            v1_b_q <= serve_s & req_b;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_W-1:0] do_a_q, do_b_q;
            logic              v2_a_q, v2_b_q;

            // Read stage 2: optional output register, also frozen by en
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    do_a_q <= {DATA_W{1'b0}};
                    do_b_q <= {DATA_W{1'b0}};
                    v2_a_q <= 1'b0;
                    v2_b_q <= 1'b0;
                end else if (en) begin
                    do_a_q <= rd_a_q;
                    do_b_q <= rd_b_q;
                    v2_a_q <= v1_a_q;
                    v2_b_q <= v1_b_q;
                end
            end

            assign dout_a = do_a_q;
            assign dout_b = do_b_q;
            assign vld_a  = v2_a_q;
            assign vld_b  = v2_b_q;
        end else begin : g_no_out_reg
            assign dout_a = rd_a_q;
            assign dout_b = rd_b_q;
            assign vld_a  = v1_a_q;
            assign vld_b  = v1_b_q;
        end
    endgenerate

    assign load_ready = load_ready_q;
    assign busy       = busy_q;
    assign load_done  = load_done_q;
    assign table_ok   = table_ok_q;
    assign drop_err   = drop_err_q;

endmodule
